centroid_calc: RTL and testbench
================================

CENTROID_CALC -- requirements
Module: centroid_calc

Interface
REQ-001 SHALL have parameter COORD_W, default 10: width of the pixel X/Y coordinate and centroid outputs.
REQ-002 SHALL have parameter CNT_W, default 19: width of the hit-pixel counter.
REQ-003 SHALL have parameter MIN_PIXELS, default 16: minimum hits per frame for a valid centroid.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port iPix_Val, input, 1: pixel coordinate valid this cycle.
REQ-007 SHALL have port iPix_Hit, input, 1: pixel matches the target; ignored when iPix_Val=0.
REQ-008 SHALL have port iX, input, COORD_W: pixel column.
REQ-009 SHALL have port iY, input, COORD_W: pixel row.
REQ-010 SHALL have port iFrame_End, input, 1: one-cycle pulse closing the current frame.
REQ-011 SHALL have port oCent_X, output, COORD_W: centroid column.
REQ-012 SHALL have port oCent_Y, output, COORD_W: centroid row.
REQ-013 SHALL have port oCent_Val, output, 1: one-cycle pulse, new centroid on oCent_X/Y; feeds the tracking_buffer oCent_Val input.
REQ-014 SHALL have port oBusy, output, 1: high while a division is in progress.
REQ-015 SHALL have port oDrop, output, 1: one-cycle pulse, a frame result was discarded.

Function
REQ-016 SHALL, when iPix_Val=1 and iPix_Hit=1, add iX to sum_x, add iY to sum_y and increment cnt at the next edge; sums are SUM_W = COORD_W+CNT_W bits wide.
REQ-017 SHALL saturate cnt at 2^CNT_W-1 and, once saturated, stop updating sum_x, sum_y and cnt until the frame closes.
REQ-018 SHALL count a hit that arrives in the same cycle as iFrame_End toward the closing frame.
REQ-019 SHALL, on iFrame_End, snapshot {sum_x, sum_y, cnt} including any same-cycle hit, and clear the accumulators so the next frame accumulates from zero at the following edge.
REQ-020 SHALL implement FSM states IDLE, DIV and DONE.
REQ-021 SHALL, in IDLE on iFrame_End with snapshot cnt >= MIN_PIXELS, go to DIV.
REQ-022 SHALL, in IDLE on iFrame_End with snapshot cnt < MIN_PIXELS, stay in IDLE with no oCent_Val, holding oCent_X/Y.
REQ-023 SHALL, in DIV, run two parallel restoring dividers (sum_x/cnt, sum_y/cnt) producing one quotient bit per cycle for exactly SUM_W cycles, then go to DONE.
REQ-024 SHALL, in DONE, load oCent_X/Y with the low COORD_W bits of the floor quotients, pulse oCent_Val for one cycle, and return to IDLE.
REQ-025 SHALL assert oCent_Val exactly SUM_W+2 cycles after the edge that samples iFrame_End (31 at defaults).
REQ-026 SHALL assert oBusy in DIV and DONE.
REQ-027 SHALL keep accumulating the next frame during DIV/DONE.
REQ-028 SHALL, on iFrame_End while oBusy=1, discard that frame's snapshot, clear the accumulators, pulse oDrop for one cycle and leave the running division unaffected.
REQ-029 SHALL hold oCent_X/Y between valid results.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously set state=IDLE, sums=0, cnt=0, oCent_X=0, oCent_Y=0, oCent_Val=0, oBusy=0, oDrop=0, including mid-division, producing no oCent_Val for the aborted frame.
REQ-031 SHALL resume normal operation at the first edge after rst_n deasserts.

Verification
REQ-032 SHALL pass: 16 hits at (100,50) then iFrame_End -> oCent_X=100, oCent_Y=50, oCent_Val pulse 31 cycles later, oBusy high in between.
REQ-033 SHALL pass: 4x4 hit block x=10..13, y=20..23 (cnt=16, sum_x=184, sum_y=344) -> oCent_X=11, oCent_Y=21.
REQ-034 SHALL pass: 15 hits then iFrame_End -> no oCent_Val, oBusy stays 0, oCent_X/Y keep the prior values.
REQ-035 SHALL pass: second iFrame_End 10 cycles after the first -> oDrop one-cycle pulse, exactly one oCent_Val carrying the first frame's result; the next frame starts from zero sums.
REQ-036 SHALL pass: hit on the iFrame_End cycle -> included in the closing frame (e.g. 15 prior hits + 1 same-cycle hit yields oCent_Val).
REQ-037 SHALL pass: rst_n pulsed low during DIV -> all outputs 0 immediately, no oCent_Val afterward, next valid frame produces the correct centroid.

Source files
------------

// File: rtl/centroid_calc.sv
// Frame centroid engine: accumulates hit-pixel coordinates per frame and divides the
// sums by the hit count with two bit-serial restoring dividers running in parallel.
module centroid_calc #(
    parameter int COORD_W    = 10,
    parameter int CNT_W      = 19,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iPix_Val,
    input  logic               iPix_Hit,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iFrame_End,
    output logic [COORD_W-1:0] oCent_X,
    output logic [COORD_W-1:0] oCent_Y,
    output logic               oCent_Val,
    output logic               oBusy,
    output logic               oDrop
);

    localparam int SUM_W  = COORD_W + CNT_W;
    localparam int STEP_W = $clog2(SUM_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   quo_x_q, quo_x_d, quo_y_q, quo_y_d;
    logic [CNT_W-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [CNT_W-1:0]   dvs_q, dvs_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [COORD_W-1:0] cent_x_q, cent_x_d, cent_y_q, cent_y_d;
    logic               val_q, val_d, busy_q, busy_d, drop_q, drop_d;

    logic               hit_s;
    logic [SUM_W-1:0]   acc_x_s, acc_y_s;
    logic [CNT_W-1:0]   acc_cnt_s;

    // One restoring-division iteration; returns {remainder, shifted quotient/dividend}.
    function automatic logic [CNT_W+SUM_W-1:0] div_step(
        input logic [CNT_W-1:0] rem,
        input logic [SUM_W-1:0] quo,
        input logic [CNT_W-1:0] dvs
    );
        logic [CNT_W:0] trial;
        logic [CNT_W:0] diff;
        trial = {rem, quo[SUM_W-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            return {diff[CNT_W-1:0], quo[SUM_W-2:0], 1'b1};
        end else begin
            return {trial[CNT_W-1:0], quo[SUM_W-2:0], 1'b0};
        end
    endfunction

    // Accumulation, frame snapshot and divider FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        quo_x_d  = quo_x_q;
        quo_y_d  = quo_y_q;
        rem_x_d  = rem_x_q;
        rem_y_d  = rem_y_q;
        dvs_d    = dvs_q;
        step_d   = step_q;
        cent_x_d = cent_x_q;
        cent_y_d = cent_y_q;
        val_d    = 1'b0;
        drop_d   = 1'b0;

        // A saturated counter freezes the whole frame's accumulation.
        hit_s = iPix_Val & iPix_Hit & (cnt_q != CNT_MAX);
        if (hit_s) begin
            acc_x_s   = sum_x_q + {{CNT_W{1'b0}}, iX};
            acc_y_s   = sum_y_q + {{CNT_W{1'b0}}, iY};
            acc_cnt_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_x_s   = sum_x_q;
            acc_y_s   = sum_y_q;
            acc_cnt_s = cnt_q;
        end

        if (iFrame_End) begin
            sum_x_d = {SUM_W{1'b0}};
            sum_y_d = {SUM_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            sum_x_d = acc_x_s;
            sum_y_d = acc_y_s;
            cnt_d   = acc_cnt_s;
        end

        case (state_q)
            S_IDLE: begin
                if (iFrame_End && (acc_cnt_s >= MIN_CNT)) begin
                    state_d = S_DIV;
                    quo_x_d = acc_x_s;
                    quo_y_d = acc_y_s;
                    dvs_d   = acc_cnt_s;
                    rem_x_d = {CNT_W{1'b0}};
                    rem_y_d = {CNT_W{1'b0}};
                    step_d  = {STEP_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                drop_d = iFrame_End;
                step_d = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
                // Step 0 is an alignment cycle so the result pulse lands SUM_W+2 edges after the frame end.
                if (step_q != {STEP_W{1'b0}}) begin
                    {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, dvs_q);
                    {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, dvs_q);
                end else begin
                    rem_x_d = rem_x_q;
                    rem_y_d = rem_y_q;
                end
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                drop_d   = iFrame_End;
                cent_x_d = quo_x_q[COORD_W-1:0];
                cent_y_d = quo_y_q[COORD_W-1:0];
                val_d    = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sum_x_q  <= {SUM_W{1'b0}};
            sum_y_q  <= {SUM_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            quo_x_q  <= {SUM_W{1'b0}};
            quo_y_q  <= {SUM_W{1'b0}};
            rem_x_q  <= {CNT_W{1'b0}};
            rem_y_q  <= {CNT_W{1'b0}};
            dvs_q    <= {CNT_W{1'b0}};
            step_q   <= {STEP_W{1'b0}};
            cent_x_q <= {COORD_W{1'b0}};
            cent_y_q <= {COORD_W{1'b0}};
            val_q    <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            cnt_q    <= cnt_d;
            quo_x_q  <= quo_x_d;
            quo_y_q  <= quo_y_d;
            rem_x_q  <= rem_x_d;
            rem_y_q  <= rem_y_d;
            dvs_q    <= dvs_d;
            step_q   <= step_d;
            cent_x_q <= cent_x_d;
            cent_y_q <= cent_y_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign oCent_X   = cent_x_q;
    assign oCent_Y   = cent_y_q;
    assign oCent_Val = val_q;
    assign oBusy     = busy_q;
    assign oDrop     = drop_q;

endmodule

// File: tb/tb_centroid_calc.sv
// Self-checking bench for centroid_calc: directed and randomized frames against a
// plain-arithmetic mean-of-hits reference model.
module tb_centroid_calc;

    localparam int LAT     = 31;
    localparam int MIN_PIX = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_val = 1'b0, pix_hit = 1'b0, frame_end = 1'b0;
    logic [9:0] px = 10'd0, py = 10'd0;
    logic [9:0] cent_x, cent_y;
    logic       cent_val, busy, drop;

    int checks = 0;
    int errors = 0;

    // reference model: running frame sums and last published centroid
    longint     fsx, fsy;
    int         fn;
    logic [9:0] exp_x = 10'd0, exp_y = 10'd0;

    always #5 clk = ~clk;

    centroid_calc dut (
        .clk(clk), .rst_n(rst_n), .iPix_Val(pix_val), .iPix_Hit(pix_hit),
        .iX(px), .iY(py), .iFrame_End(frame_end),
        .oCent_X(cent_x), .oCent_Y(cent_y), .oCent_Val(cent_val),
        .oBusy(busy), .oDrop(drop)
    );

    task automatic drive(input logic v, input logic h, input logic [9:0] x,
                         input logic [9:0] y, input logic fe);
        @(negedge clk);
        pix_val = v; pix_hit = h; px = x; py = y; frame_end = fe;
        if (v && h) begin
            fsx += x; fsy += y; fn++;
        end
    endtask

    task automatic frame_reset();
        fsx = 0; fsy = 0; fn = 0;
    endtask

    task automatic rand_hit();
        drive(1'b1, 1'b1, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 1'b0);
    endtask

    // Watches outputs after the frame-end edge; returns what it saw, no judging.
    task automatic observe(input int max_cyc, output int first_val, output int nval,
                           output int nbusy, output logic [9:0] ox, output logic [9:0] oy);
        first_val = -1; nval = 0; nbusy = 0; ox = 10'd0; oy = 10'd0;
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        if (busy) nbusy++;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (cent_val) begin
                nval++;
                if (first_val < 0) begin
                    first_val = k; ox = cent_x; oy = cent_y;
                end
            end
            if (k < LAT && busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cent_x, cent_y, cent_val, busy, drop} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {cent_x, cent_y, cent_val, busy, drop});
        end
        rst_n = 1'b1;
        frame_reset();
    endtask

    task automatic test_basic();
        int lat, nv, nb; logic [9:0] ox, oy;
        frame_reset();
        repeat (16) drive(1'b1, 1'b1, 10'd100, 10'd50, 1'b0);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL basic_pulses: got %0d required 1", nv); end
        checks++; if ({ox, oy} !== {exp_x, exp_y}) begin errors++; $display("FAIL basic_value: got %0d,%0d required %0d,%0d", ox, oy, exp_x, exp_y); end
        checks++; if (nb !== LAT) begin errors++; $display("FAIL basic_busy: got %0d busy samples required %0d", nb, LAT); end
        frame_reset();
    endtask

    task automatic test_block();
        int lat, nv, nb; logic [9:0] ox, oy;
        frame_reset();
        for (int y = 20; y <= 23; y++)
            for (int x = 10; x <= 13; x++)
                drive(1'b1, 1'b1, 10'(x), 10'(y), 1'b0);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
        checks++; if ({ox, oy} !== {exp_x, exp_y} || lat !== LAT) begin errors++; $display("FAIL block_value: got %0d,%0d at %0d required %0d,%0d at %0d", ox, oy, lat, exp_x, exp_y, LAT); end
        frame_reset();
    endtask

    task automatic test_short();
        int lat, nv, nb; logic [9:0] ox, oy;
        frame_reset();
        repeat (MIN_PIX - 1) rand_hit();
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        checks++; if (nv !== 0) begin errors++; $display("FAIL short_no_val: got %0d pulses required 0", nv); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL short_busy: got %0d busy samples required 0", nb); end
        checks++; if ({cent_x, cent_y} !== {exp_x, exp_y}) begin errors++; $display("FAIL short_hold: got %0d,%0d required %0d,%0d", cent_x, cent_y, exp_x, exp_y); end
        frame_reset();
    endtask

    task automatic test_same_cycle();
        int lat, nv, nb; logic [9:0] ox, oy;
        frame_reset();
        repeat (MIN_PIX - 1) rand_hit();
        drive(1'b1, 1'b1, 10'd1000, 10'd900, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
        checks++; if (nv !== 1 || lat !== LAT) begin errors++; $display("FAIL same_cycle_val: got %0d pulses at %0d required 1 at %0d", nv, lat, LAT); end
        checks++; if ({ox, oy} !== {exp_x, exp_y}) begin errors++; $display("FAIL same_cycle_value: got %0d,%0d required %0d,%0d", ox, oy, exp_x, exp_y); end
        frame_reset();
    endtask

    task automatic test_random();
        int lat, nv, nb, npix; logic [9:0] ox, oy; logic v, h;
        for (int f = 0; f < 10; f++) begin
            frame_reset();
            npix = $urandom_range(10, 60);
            for (int p = 0; p < npix; p++) begin
                v = ($urandom_range(0, 3) != 0);
                h = ($urandom_range(0, 2) != 0);
                drive(v, h, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 1'b0);
            end
            drive(1'b1, ($urandom_range(0, 1) != 0), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 1'b1);
            observe(45, lat, nv, nb, ox, oy);
            if (fn >= MIN_PIX) begin
                exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
                checks++; if (nv !== 1 || lat !== LAT || {ox, oy} !== {exp_x, exp_y}) begin errors++; $display("FAIL random_frame%0d: got %0d pulses at %0d value %0d,%0d required 1 at %0d value %0d,%0d", f, nv, lat, ox, oy, LAT, exp_x, exp_y); end
            end else begin
                checks++; if (nv !== 0 || {cent_x, cent_y} !== {exp_x, exp_y}) begin errors++; $display("FAIL random_short%0d: got %0d pulses value %0d,%0d required 0 pulses value %0d,%0d", f, nv, cent_x, cent_y, exp_x, exp_y); end
            end
        end
        frame_reset();
    endtask

    task automatic test_back_to_back();
        int lat, nv, nb, ndrop; logic [9:0] ox, oy, ax, ay; logic drop_at_10;
        frame_reset();
        repeat (20) rand_hit();
        ax = 10'(fsx / fn); ay = 10'(fsy / fn);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        lat = -1; nv = 0; ndrop = 0; drop_at_10 = 1'b0; ox = 10'd0; oy = 10'd0;
        for (int k = 1; k <= 45; k++) begin
            if (k <= 8) rand_hit();
            else if (k == 9) drive(1'b1, 1'b1, 10'd7, 10'd7, 1'b1);
            else drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
            if (drop) ndrop++;
            if (k == 10) drop_at_10 = drop;
            if (cent_val) begin
                nv++;
                if (lat < 0) begin lat = k; ox = cent_x; oy = cent_y; end
            end
        end
        exp_x = ax; exp_y = ay;
        checks++; if (ndrop !== 1 || drop_at_10 !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0d pulses at10=%0b required 1 at10=1", ndrop, drop_at_10); end
        checks++; if (nv !== 1 || lat !== LAT) begin errors++; $display("FAIL drop_single_val: got %0d pulses at %0d required 1 at %0d", nv, lat, LAT); end
        checks++; if ({ox, oy} !== {ax, ay}) begin errors++; $display("FAIL drop_first_value: got %0d,%0d required %0d,%0d", ox, oy, ax, ay); end
        frame_reset();
        repeat (16) rand_hit();
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
        checks++; if (nv !== 1 || {ox, oy} !== {exp_x, exp_y}) begin errors++; $display("FAIL drop_next_frame: got %0d pulses value %0d,%0d required 1 value %0d,%0d", nv, ox, oy, exp_x, exp_y); end
        frame_reset();
    endtask

    task automatic test_reset_mid_div();
        int lat, nv, nb; logic [9:0] ox, oy;
        frame_reset();
        repeat (20) rand_hit();
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({cent_x, cent_y, cent_val, busy, drop} !== 23'd0) begin errors++; $display("FAIL reset_mid_div: got %h required 0", {cent_x, cent_y, cent_val, busy, drop}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_x = 10'd0; exp_y = 10'd0;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cent_val) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL reset_no_val: got %0d pulses required 0", nv); end
        frame_reset();
        repeat (24) rand_hit();
        drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        observe(45, lat, nv, nb, ox, oy);
        exp_x = 10'(fsx / fn); exp_y = 10'(fsy / fn);
        checks++; if (nv !== 1 || lat !== LAT || {ox, oy} !== {exp_x, exp_y}) begin errors++; $display("FAIL reset_recover: got %0d pulses at %0d value %0d,%0d required 1 at %0d value %0d,%0d", nv, lat, ox, oy, LAT, exp_x, exp_y); end
        frame_reset();
    endtask

    initial begin
        frame_reset();
        test_reset();
        test_basic();
        test_block();
        test_short();
        test_same_cycle();
        test_random();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
